mem_port_arbiter: RTL and testbench

Shares the processor's single-port synchronous memory between three requesters: the data path (ld/st), instruction fetch, and an external loader/debug port. It replaces the ad-hoc `mem_sel` steering with a grant/valid handshake. It drives the RAM address, write-enable and write-data, routes read-valid back to the requester that owns each read, and prevents the external port from being starved or from monopolising memory.

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the data path, instruction fetch and the
// external loader/debug port. Combinational grant, registered read return.
// The external port has a starvation override and a capped locked burst
// that ends in a one-cycle cooldown.
module mem_port_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  input  logic          x_req,
  input  logic          x_we,
  input  logic          x_lock,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  output logic          x_gnt,
  output logic          x_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [WW-1:0] WAIT_LIM  = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

  typedef enum logic [1:0] {ST_OPEN, ST_LOCKED, ST_COOL} state_t;
  typedef enum logic [1:0] {OWN_D, OWN_F, OWN_X} owner_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [BW-1:0] burst_q, burst_d, burst_inc;
  owner_t        owner_q, owner_d;
  logic          rd_q, rd_d;

  // Fixed-priority grant; an unlocked LOCKED state releases in the same cycle.
  always_comb begin
    d_gnt = 1'b0;
    f_gnt = 1'b0;
    x_gnt = 1'b0;
    if (!reset) begin
      if (state_q == ST_LOCKED && x_req && x_lock)                   x_gnt = 1'b1;
      else if (x_req && wait_q == WAIT_LIM && state_q != ST_COOL)    x_gnt = 1'b1;
      else if (d_req)                                                d_gnt = 1'b1;
      else if (f_req)                                                f_gnt = 1'b1;
      else if (x_req && state_q != ST_COOL)                          x_gnt = 1'b1;
    end
  end

  // Steer the winner onto the RAM port; idle port parks on the data path.
  always_comb begin
    mem_en    = d_gnt | f_gnt | x_gnt;
    mem_we    = 1'b0;
    mem_addr  = d_addr;
    mem_wdata = d_wdata;
    owner_d   = OWN_D;
    if (x_gnt) begin
      mem_we    = x_we;
      mem_addr  = x_addr;
      mem_wdata = x_wdata;
      owner_d   = OWN_X;
    end else if (f_gnt) begin
      mem_addr  = f_addr;
      owner_d   = OWN_F;
    end else if (d_gnt) begin
      mem_we    = d_we;
    end
    rd_d = mem_en & ~mem_we;
  end

  // Starvation counter and burst state machine next-state.
  always_comb begin
    wait_d    = wait_q;
    state_d   = state_q;
    burst_d   = burst_q;
    burst_inc = burst_q + BW'(1);
    if (x_gnt || !x_req)        wait_d = '0;
    else if (wait_q != WAIT_LIM) wait_d = wait_q + WW'(1);
    case (state_q)
      ST_OPEN: begin
        if (x_gnt && x_lock) begin
          burst_d = BW'(1);
          state_d = (BURST_MAX == 1) ? ST_COOL : ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (!x_req || !x_lock) begin
          state_d = ST_OPEN;
          burst_d = '0;
        end else if (x_gnt) begin
          burst_d = burst_inc;
          if (burst_inc == BURST_LIM) state_d = ST_COOL;
        end
      end
      ST_COOL: begin
        state_d = ST_OPEN;
        burst_d = '0;
      end
      default: begin
        state_d = ST_OPEN;
        burst_d = '0;
      end
    endcase
  end

  // State registers; reset also discards any read in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_OPEN;
      wait_q  <= '0;
      burst_q <= '0;
      owner_q <= OWN_D;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
      owner_q <= owner_d;
      rd_q    <= rd_d;
    end
  end

  assign d_rvalid = rd_q && (owner_q == OWN_D);
  assign f_rvalid = rd_q && (owner_q == OWN_F);
  assign x_rvalid = rd_q && (owner_q == OWN_X);
  assign rdata    = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a RAM model and a read-return
// scoreboard: each expected read grant queues the rvalid/rdata due next step.
module tb_mem_port_arbiter;
  localparam int AW = 16, DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          d_req = 0, d_we = 0, f_req = 0, x_req = 0, x_we = 0, x_lock = 0;
  logic [AW-1:0] d_addr = '0, f_addr = '0, x_addr = '0;
  logic [DW-1:0] d_wdata = '0, x_wdata = '0;
  logic          d_gnt, d_rvalid, f_gnt, f_rvalid, x_gnt, x_rvalid;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(8), .BURST_MAX(16)) dut (
    .clk(clk), .reset(reset),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .x_req(x_req), .x_we(x_we), .x_lock(x_lock), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_gnt(x_gnt), .x_rvalid(x_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return (a * 16'd3) ^ 16'h5A00;
  endfunction

  // RAM model: registered read, unwritten words read back a fixed pattern.
  logic [DW-1:0] ram [256];
  logic [255:0]  ram_v = '0;
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      ram[mem_addr[7:0]]   <= mem_wdata;
      ram_v[mem_addr[7:0]] <= 1'b1;
    end else if (mem_en) begin
      ram_q <= ram_v[mem_addr[7:0]] ? ram[mem_addr[7:0]] : pat(mem_addr);
    end
  end
  assign mem_rdata = ram_q;

  // Bench-side shadow of writes, for expected read data.
  logic [DW-1:0] shadow [256];
  logic [255:0]  shv = '0;

  typedef struct {int at; logic [2:0] own; logic [DW-1:0] data;} rd_t;
  rd_t sbq[$];

  int n_assert = 0;
  int n_fail   = 0;
  int stp      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (step %0d): observed %0h required %0h", tag, stp, obs, exp);
    end
  endtask

  // One cycle: eg = expected {d,f,x} grant with the inputs currently driven.
  task automatic step(input logic [2:0] eg);
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    logic          ew;
    rd_t           e;
    @(negedge clk);
    ea = d_addr; ewd = d_wdata; ew = 1'b0;
    if (eg[2])      begin ea = d_addr; ew = d_we; ewd = d_wdata; end
    else if (eg[1]) begin ea = f_addr; ew = 1'b0; end
    else if (eg[0]) begin ea = x_addr; ew = x_we; ewd = x_wdata; end
    chk("gnt",      {29'd0, d_gnt, f_gnt, x_gnt}, {29'd0, eg});
    chk("mem_en",   {31'd0, mem_en}, {31'd0, |eg});
    chk("mem_we",   {31'd0, mem_we}, {31'd0, ew});
    chk("mem_addr", {16'd0, mem_addr}, {16'd0, ea});
    if (ew) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, ewd});
    if (sbq.size() > 0 && sbq[0].at == stp) begin
      e = sbq.pop_front();
      chk("rvalid", {29'd0, d_rvalid, f_rvalid, x_rvalid}, {29'd0, e.own});
      chk("rdata",  {16'd0, rdata}, {16'd0, e.data});
    end else begin
      chk("rvalid_idle", {29'd0, d_rvalid, f_rvalid, x_rvalid}, 32'd0);
    end
    if (|eg) begin
      if (ew) begin
        shadow[ea[7:0]] = ewd;
        shv[ea[7:0]]    = 1'b1;
      end else begin
        e.at = stp + 1; e.own = eg;
        e.data = shv[ea[7:0]] ? shadow[ea[7:0]] : pat(ea);
        sbq.push_back(e);
      end
    end
    stp++;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset with every requester asking: nothing granted, nothing valid.
    d_req = 1; d_addr = 16'h0010; f_req = 1; f_addr = 16'h0020;
    x_req = 1; x_addr = 16'h0040;
    step(3'b000);
    step(3'b000);
    reset = 0;
    step(3'b100);                       // first post-reset cycle: data, read 0x10
    x_req = 0; d_req = 0;
    step(3'b010);                       // fetch read 0x20, d_rvalid returns
    f_req = 0;
    step(3'b000);                       // f_rvalid returns

    // Data write then read-back, back-to-back with a fetch read.
    d_req = 1; d_we = 1; d_addr = 16'h0030; d_wdata = 16'hBEEF;
    step(3'b100);
    d_we = 0;
    step(3'b100);
    d_req = 0; f_req = 1; f_addr = 16'h0021;
    step(3'b010);
    f_req = 0;
    step(3'b000);

    // Starvation: continuous data traffic, external wins on the 9th cycle.
    d_req = 1; d_addr = 16'h0011; x_req = 1; x_addr = 16'h0050;
    for (int i = 0; i < 8; i++) step(3'b100);
    step(3'b001);
    step(3'b100);
    step(3'b100);
    d_req = 0; x_req = 0;
    step(3'b000);

    // Locked burst under data pressure: 16 grants, cooldown, regrant.
    d_req = 1; d_addr = 16'h0012; x_req = 1; x_lock = 1; x_addr = 16'h0060;
    for (int i = 0; i < 8; i++) step(3'b100);
    for (int i = 0; i < 16; i++) step(3'b001);
    step(3'b100);                       // cooldown: ext blocked, data served
    d_req = 0;
    step(3'b001);                       // ext grantable again
    x_req = 0;
    step(3'b000);

    // Lock drop with fetch pending: fetch granted in the release cycle.
    x_req = 1; x_lock = 1; x_we = 1; x_addr = 16'h0070; x_wdata = 16'h1234;
    step(3'b001);
    x_we = 0; f_req = 1; f_addr = 16'h0070;
    for (int i = 0; i < 4; i++) step(3'b001);
    x_lock = 0;
    step(3'b010);                       // reads back the external write
    f_req = 0;
    step(3'b001);                       // unlocked ext by plain priority
    x_req = 0;
    step(3'b000);

    // Reset mid-burst with a read outstanding: no rvalid survives.
    x_req = 1; x_lock = 1; x_addr = 16'h0080;
    for (int i = 0; i < 7; i++) step(3'b001);
    reset = 1; sbq.delete(); d_req = 1; d_addr = 16'h0013;
    step(3'b000);
    step(3'b000);
    reset = 0;
    step(3'b100);                       // data beats the still-locked ext request
    d_req = 0;
    step(3'b001);
    x_req = 0; x_lock = 0;
    step(3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
